// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator CPU core: opcode encoding, sequencer states
// and the opcode field width.
package acc_cpu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LDR  = 4'h2,
        OP_STR  = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_XOR  = 4'h7,
        OP_JMP  = 4'h8,
        OP_JZ   = 4'h9,
        OP_MUL  = 4'hA,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DECODE  = 2'd1,
        ST_EXECUTE = 2'd2,
        ST_HALT    = 2'd3
    } state_e;

endpackage

// File: rtl/acc_cpu_core_if.sv
// Instruction-fetch bus between the core (master) and instruction memory (slave).
// Handshake: a word transfers on a rising clk edge where fetch_req (ready) and instr_valid are both 1.
interface acc_cpu_core_if #(
    parameter int OPERAND_W = 4,
    parameter int PC_W      = 8
);
    logic [acc_cpu_pkg::OPC_W+OPERAND_W-1:0] instr;
    logic                                    instr_valid;
    logic                                    fetch_req;
    logic [PC_W-1:0]                         instr_addr;

    modport master (input instr, input instr_valid, output fetch_req, output instr_addr);
    modport slave  (output instr, output instr_valid, input fetch_req, input instr_addr);
endinterface

// File: rtl/acc_cpu_regfile.sv
// Register file: one combinational read port, one synchronous write port, async clear.
// Indices at or above NUM_REGS read as zero and silently drop writes.
module acc_cpu_regfile #(
    parameter int DATA_W    = 8,
    parameter int NUM_REGS  = 16,
    parameter int OPERAND_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [OPERAND_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0]    o_rd_data,
    input  logic                 i_wr_en,
    input  logic [OPERAND_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]    i_wr_data
);
    logic [DATA_W-1:0] r_mem [NUM_REGS];

    // Full-width index match per entry so no out-of-range index ever aliases onto a real register.
    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_rd_addr == OPERAND_W'(i)) o_rd_data = r_mem[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_wr_en && (i_wr_addr == OPERAND_W'(i))) r_mem[i] <= i_wr_data;
            end
        end
    end
endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core (FETCH/DECODE/EXECUTE/HALT) with PC, flags and branches.
// Define ACC_CPU_MUL_EN to make opcode A a multiply; otherwise it executes as NOP.
module acc_cpu_core
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int OPERAND_W = 4,
    parameter int NUM_REGS  = 16,
    parameter int PC_W      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    acc_cpu_core_if.master        fetch_if,
    output logic [DATA_W-1:0]     acc_out,
    output logic                  zero_flag,
    output logic                  carry_flag,
    output logic                  halted,
    output state_e                o_dbg_state
);
    state_e                      r_state;
    logic [PC_W-1:0]             r_pc;
    logic [OPC_W+OPERAND_W-1:0]  r_ir;
    logic [DATA_W-1:0]           r_opnd;
    logic [DATA_W-1:0]           r_acc;
    logic                        r_zero;
    logic                        r_carry;

    state_e                      w_state_nxt;
    logic                        w_fetch_req;
    logic                        w_halted;
    logic                        w_hs;
    opcode_t                     w_opcode;
    logic [OPERAND_W-1:0]        w_operand;
    logic [DATA_W-1:0]           w_rd_data;
    logic [DATA_W:0]             w_sum;
    logic [DATA_W:0]             w_diff;
    logic                        w_acc_we;
    logic [DATA_W-1:0]           w_acc_nxt;
    logic                        w_carry_we;
    logic                        w_carry_nxt;
    logic                        w_rf_we;
    logic                        w_pc_load;

    assign w_opcode  = opcode_t'(r_ir[OPC_W+OPERAND_W-1 -: OPC_W]);
    assign w_operand = r_ir[OPERAND_W-1:0];
    assign w_hs      = w_fetch_req && fetch_if.instr_valid;
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_opnd};
    assign w_diff    = {1'b0, r_acc} - {1'b0, r_opnd};

`ifdef ACC_CPU_MUL_EN
    logic [DATA_W-1:0] w_mul;
    assign w_mul = r_acc * r_opnd;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_FETCH;
        else        r_state <= w_state_nxt;
    end

    // Ready is gated by reset so it stays low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_fetch_req = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_fetch_req = reset;
                if (reset && fetch_if.instr_valid) w_state_nxt = ST_DECODE;
            end
            ST_DECODE:  w_state_nxt = ST_EXECUTE;
            ST_EXECUTE: w_state_nxt = (w_opcode == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:    w_halted    = 1'b1;
            default:    w_state_nxt = ST_FETCH;
        endcase
    end

    always_comb begin
        w_acc_we    = 1'b0;
        w_acc_nxt   = r_acc;
        w_carry_we  = 1'b0;
        w_carry_nxt = r_carry;
        w_rf_we     = 1'b0;
        w_pc_load   = 1'b0;
        if (r_state == ST_EXECUTE) begin
            case (w_opcode)
                OP_LDI: begin w_acc_we = 1'b1; w_acc_nxt = DATA_W'(w_operand); end
                OP_LDR: begin w_acc_we = 1'b1; w_acc_nxt = r_opnd; end
                OP_STR: w_rf_we = 1'b1;
                OP_ADD: begin
                    w_acc_we    = 1'b1;
                    w_acc_nxt   = w_sum[DATA_W-1:0];
                    w_carry_we  = 1'b1;
                    w_carry_nxt = w_sum[DATA_W];
                end
                OP_SUB: begin
                    w_acc_we    = 1'b1;
                    w_acc_nxt   = w_diff[DATA_W-1:0];
                    w_carry_we  = 1'b1;
                    w_carry_nxt = w_diff[DATA_W];
                end
                OP_AND: begin w_acc_we = 1'b1; w_acc_nxt = r_acc & r_opnd; end
                OP_XOR: begin w_acc_we = 1'b1; w_acc_nxt = r_acc ^ r_opnd; end
                OP_JMP: w_pc_load = 1'b1;
                OP_JZ:  w_pc_load = r_zero;
`ifdef ACC_CPU_MUL_EN
                OP_MUL: begin w_acc_we = 1'b1; w_acc_nxt = w_mul; end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
            r_zero  <= 1'b1;
            r_carry <= 1'b0;
        end else begin
            if (w_hs) begin
                r_ir <= fetch_if.instr;
                r_pc <= r_pc + PC_W'(1);
            end
            if (r_state == ST_DECODE) r_opnd <= w_rd_data;
            // A taken branch in EXECUTE overrides the increment done during FETCH.
            if (w_pc_load) r_pc <= PC_W'(w_operand);
            if (w_acc_we) begin
                r_acc  <= w_acc_nxt;
                r_zero <= (w_acc_nxt == '0);
            end
            if (w_carry_we) r_carry <= w_carry_nxt;
        end
    end

    acc_cpu_regfile #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .OPERAND_W (OPERAND_W)
    ) u_regfile (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_rd_addr (w_operand),
        .o_rd_data (w_rd_data),
        .i_wr_en   (w_rf_we),
        .i_wr_addr (w_operand),
        .i_wr_data (r_acc)
    );

    assign fetch_if.fetch_req  = w_fetch_req;
    assign fetch_if.instr_addr = r_pc;
    assign acc_out             = r_acc;
    assign zero_flag           = r_zero;
    assign carry_flag          = r_carry;
    assign halted              = w_halted;
    assign o_dbg_state         = r_state;
endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: default core (OPERAND_W=4) plus a second core with
// OPERAND_W=5 for the out-of-range register index cases.
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;

`ifdef ACC_CPU_MUL_EN
  localparam logic [7:0] MUL_EXP = 8'd15;
`else
  localparam logic [7:0] MUL_EXP = 8'd5;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  acc_cpu_core_if #(.OPERAND_W(4), .PC_W(8)) ifa ();
  acc_cpu_core_if #(.OPERAND_W(5), .PC_W(8)) ifb ();

  logic [7:0] acc_a, acc_b;
  logic       zero_a, carry_a, halted_a;
  logic       zero_b, carry_b, halted_b;
  state_e     state_a, state_b;

  acc_cpu_core #(.DATA_W(8), .OPERAND_W(4), .NUM_REGS(16), .PC_W(8)) u_dut (
    .clk(clk), .reset(reset), .fetch_if(ifa.master),
    .acc_out(acc_a), .zero_flag(zero_a), .carry_flag(carry_a),
    .halted(halted_a), .o_dbg_state(state_a)
  );

  acc_cpu_core #(.DATA_W(8), .OPERAND_W(5), .NUM_REGS(16), .PC_W(8)) u_dut5 (
    .clk(clk), .reset(reset), .fetch_if(ifb.master),
    .acc_out(acc_b), .zero_flag(zero_b), .carry_flag(carry_b),
    .halted(halted_b), .o_dbg_state(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_fetch(input bit sel);
    int n = 0;
    while (((sel ? ifb.fetch_req : ifa.fetch_req) !== 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("fetch_timeout", sel ? ifb.fetch_req : ifa.fetch_req, 1);
  endtask

  // One full instruction: handshake, then DECODE and EXECUTE; returns at the negedge after commit.
  task automatic exec(input bit sel, input logic [8:0] ins);
    wait_fetch(sel);
    if (sel) begin ifb.instr = ins; ifb.instr_valid = 1'b1; end
    else begin ifa.instr = ins[7:0]; ifa.instr_valid = 1'b1; end
    @(negedge clk);
    ifa.instr_valid = 1'b0;
    ifb.instr_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    ifa.instr = '0; ifa.instr_valid = 1'b0;
    ifb.instr = '0; ifb.instr_valid = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_fetch_req", ifa.fetch_req, 0);
    check("rst_acc", acc_a, 0);
    check("rst_zero", zero_a, 1);
    check("rst_carry", carry_a, 0);
    check("rst_halted", halted_a, 0);
    check("rst_addr", ifa.instr_addr, 0);
    check("rst_state", state_a, ST_FETCH);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_fetch_req", ifa.fetch_req, 1);

    // load/store round trip through R3
    exec(0, 9'h15); exec(0, 9'h33); exec(0, 9'h10);
    check("ldi0_zero", zero_a, 1);
    exec(0, 9'h23);
    check("ldr_r3_acc", acc_a, 8'h05);
    check("ldr_r3_zero", zero_a, 0);
    check("ldr_r3_addr", ifa.instr_addr, 4);

    // subtract with borrow, then add with carry out to zero
    exec(0, 9'h1F); exec(0, 9'h30); exec(0, 9'h10); exec(0, 9'h50);
    check("sub_acc", acc_a, 8'hF1);
    check("sub_carry", carry_a, 1);
    check("sub_zero", zero_a, 0);
    exec(0, 9'h40);
    check("add_acc", acc_a, 8'h00);
    check("add_carry", carry_a, 1);
    check("add_zero", zero_a, 1);
    check("add_addr", ifa.instr_addr, 9);

    // branches
    exec(0, 9'h82);
    check("jmp_addr", ifa.instr_addr, 2);
    exec(0, 9'h99);
    check("jz_taken_addr", ifa.instr_addr, 9);
    exec(0, 9'h11);
    check("ldi1_carry_kept", carry_a, 1);
    exec(0, 9'h99);
    check("jz_not_taken_addr", ifa.instr_addr, 11);
    check("jz_zero_kept", zero_a, 0);

    // stall in FETCH
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_fetch_req", ifa.fetch_req, 1);
      check("stall_addr", ifa.instr_addr, 11);
      check("stall_state", state_a, ST_FETCH);
    end

    // instr_valid held through DECODE/EXECUTE must not be taken
    wait_fetch(0);
    ifa.instr = 8'h17; ifa.instr_valid = 1'b1;
    @(negedge clk);
    ifa.instr = 8'h1A;
    check("busy_state_decode", state_a, ST_DECODE);
    check("busy_fetch_req", ifa.fetch_req, 0);
    @(negedge clk);
    @(negedge clk);
    ifa.instr_valid = 1'b0;
    check("busy_acc", acc_a, 8'h07);
    check("busy_addr", ifa.instr_addr, 12);

    // reserved opcode behaves as NOP
    exec(0, 9'hC5);
    check("rsvd_acc", acc_a, 8'h07);
    check("rsvd_carry", carry_a, 1);

    // PC wrap from 0xFF
    for (int i = 0; i < 300 && ifa.instr_addr != 8'hFF; i++) exec(0, 9'h00);
    check("pc_at_ff", ifa.instr_addr, 8'hFF);
    exec(0, 9'h00);
    check("pc_wrap", ifa.instr_addr, 8'h00);

    // opcode A: multiply or NOP depending on build
    exec(0, 9'h13); exec(0, 9'h31); exec(0, 9'h15); exec(0, 9'hA1);
    check("opa_acc", acc_a, MUL_EXP);
    check("opa_carry_kept", carry_a, 1);

    // HALT then ignored fetches
    exec(0, 9'hF0);
    check("halt_halted", halted_a, 1);
    check("halt_fetch_req", ifa.fetch_req, 0);
    ifa.instr = 8'h1A; ifa.instr_valid = 1'b1;
    repeat (4) @(negedge clk);
    ifa.instr_valid = 1'b0;
    check("halt_stays", halted_a, 1);
    check("halt_acc", acc_a, MUL_EXP);
    check("halt_addr", ifa.instr_addr, 5);

    // reset during EXECUTE of STR R2
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("halt_cleared", halted_a, 0);
    exec(0, 9'h19);
    wait_fetch(0);
    ifa.instr = 8'h32; ifa.instr_valid = 1'b1;
    @(negedge clk);
    ifa.instr_valid = 1'b0;
    @(negedge clk);
    check("str_in_execute", state_a, ST_EXECUTE);
    reset = 1'b0;
    #1;
    check("mid_rst_acc", acc_a, 0);
    check("mid_rst_zero", zero_a, 1);
    check("mid_rst_fetch_req", ifa.fetch_req, 0);
    check("mid_rst_addr", ifa.instr_addr, 0);
    check("mid_rst_state", state_a, ST_FETCH);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exec(0, 9'h19);
    check("ldi9_acc", acc_a, 8'h09);
    exec(0, 9'h22);
    check("r2_not_written", acc_a, 0);
    check("r2_zero", zero_a, 1);

    // wide operand core: R20 is out of range and must not alias R4
    exec(1, {4'h1, 5'd17}); exec(1, {4'h3, 5'd4});
    exec(1, {4'h1, 5'd6});  exec(1, {4'h3, 5'd20});
    exec(1, {4'h2, 5'd4});
    check("r4_no_alias", acc_b, 8'd17);
    exec(1, {4'h2, 5'd20});
    check("r20_reads_zero", acc_b, 0);
    check("r20_zero_flag", zero_b, 1);
    exec(1, {4'h1, 5'd31});
    check("ldi31_acc", acc_b, 8'd31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
